// File: rtl/tlc_pkg.sv
// Shared traffic-light types: lamp phases, default phase lengths,
// monitor fault codes and monitor states.
package tlc_pkg;

    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_NONE   = 2'd3
    } phase_e;

    localparam int unsigned DEF_RED_CYCLES    = 5;
    localparam int unsigned DEF_GREEN_CYCLES  = 5;
    localparam int unsigned DEF_YELLOW_CYCLES = 2;

    typedef enum logic [2:0] {
        FC_NONE       = 3'd0,
        FC_NOT_ONEHOT = 3'd1,
        FC_BAD_ORDER  = 3'd2,
        FC_SHORT      = 3'd3,
        FC_LONG       = 3'd4
    } fault_code_e;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FAULT   = 2'd2
    } mon_state_e;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_RED:    return PH_GREEN;
            PH_GREEN:  return PH_YELLOW;
            PH_YELLOW: return PH_RED;
            default:   return PH_NONE;
        endcase
    endfunction

    // Lamp vector is {red, yellow, green}; non-one-hot maps to PH_NONE.
    function automatic phase_e lamp_to_phase(input logic [2:0] l);
        case (l)
            3'b100:  return PH_RED;
            3'b010:  return PH_YELLOW;
            3'b001:  return PH_GREEN;
            default: return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/tlm_phase_timer.sv
// Phase duration counter: clear to 0, load 1 on a phase change,
// increment while the phase holds, and compare against the phase limit.
module tlm_phase_timer #(
    parameter int unsigned DUR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic [DUR_W-1:0] limit,
    output logic [DUR_W-1:0] dur,
    output logic             at_limit_c
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            dur <= '0;
        end else if (load) begin
            dur <= DUR_W'(1);
        end else if (inc) begin
            dur <= dur + DUR_W'(1);
        end
    end

    assign at_limit_c = (dur == limit);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp-side checker: one-hot, RED->GREEN->YELLOW order and exact
// phase lengths; latches the first fault and counts clean full cycles.
module traffic_light_monitor
    import tlc_pkg::*;
#(
    parameter int unsigned RED_CYCLES    = DEF_RED_CYCLES,
    parameter int unsigned GREEN_CYCLES  = DEF_GREEN_CYCLES,
    parameter int unsigned YELLOW_CYCLES = DEF_YELLOW_CYCLES,
    parameter int unsigned OKCNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               red,
    input  logic               yellow,
    input  logic               green,
    input  logic               clear_fault,
    output logic               fault,
    output logic [2:0]         fault_code,
    output logic               tracking,
    output logic [1:0]         phase,
    output logic               cycle_done,
    output logic [OKCNT_W-1:0] ok_cycles
);

    localparam int unsigned MAX_RG     = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_RG > YELLOW_CYCLES) ? MAX_RG : YELLOW_CYCLES;
    localparam int unsigned DUR_W      = $clog2(MAX_CYCLES + 2);

    mon_state_e  state_q, state_d;
    fault_code_e code_q, code_d;
    phase_e      phase_q, phase_d;
    phase_e      lamp_ph;
    logic        legal;
    logic        cd_d;
    logic        t_clr, t_load, t_inc;
    logic [DUR_W-1:0] limit;
    logic [DUR_W-1:0] dur;
    logic        at_limit_c;

    tlm_phase_timer #(.DUR_W(DUR_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clr        (t_clr),
        .load       (t_load),
        .inc        (t_inc),
        .limit      (limit),
        .dur        (dur),
        .at_limit_c (at_limit_c)
    );

    // Required length of the phase currently being tracked
    always_comb begin
        case (phase_q)
            PH_RED:    limit = DUR_W'(RED_CYCLES);
            PH_GREEN:  limit = DUR_W'(GREEN_CYCLES);
            PH_YELLOW: limit = DUR_W'(YELLOW_CYCLES);
            default:   limit = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ACQUIRE;
            code_q     <= FC_NONE;
            phase_q    <= PH_NONE;
            fault      <= 1'b0;
            tracking   <= 1'b0;
            cycle_done <= 1'b0;
            ok_cycles  <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            phase_q    <= phase_d;
            fault      <= (state_d == ST_FAULT);
            tracking   <= (state_d == ST_TRACK);
            cycle_done <= cd_d;
            if (cd_d && !(&ok_cycles)) begin
                ok_cycles <= ok_cycles + OKCNT_W'(1);
            end
        end
    end

    // Next state; checks ordered so lower fault codes take priority
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        phase_d = phase_q;
        cd_d    = 1'b0;
        t_clr   = 1'b0;
        t_load  = 1'b0;
        t_inc   = 1'b0;
        legal   = $onehot({red, yellow, green});
        lamp_ph = lamp_to_phase({red, yellow, green});

        if (clear_fault) begin
            state_d = ST_ACQUIRE;
            code_d  = FC_NONE;
            phase_d = PH_NONE;
            t_clr   = 1'b1;
        end else begin
            case (state_q)
                ST_ACQUIRE: begin
                    if (!legal) begin
                        state_d = ST_FAULT;
                        code_d  = FC_NOT_ONEHOT;
                    end else if (phase_q == PH_NONE) begin
                        phase_d = lamp_ph;
                    end else if (lamp_ph == phase_q) begin
                        state_d = ST_ACQUIRE;
                    end else if (lamp_ph == next_phase(phase_q)) begin
                        state_d = ST_TRACK;
                        phase_d = lamp_ph;
                        t_load  = 1'b1;
                    end else begin
                        state_d = ST_FAULT;
                        code_d  = FC_BAD_ORDER;
                    end
                end
                ST_TRACK: begin
                    if (!legal) begin
                        state_d = ST_FAULT;
                        code_d  = FC_NOT_ONEHOT;
                    end else if (lamp_ph == phase_q) begin
                        if (at_limit_c) begin
                            state_d = ST_FAULT;
                            code_d  = FC_LONG;
                        end else begin
                            t_inc = 1'b1;
                        end
                    end else if (lamp_ph == next_phase(phase_q)) begin
                        if (!at_limit_c) begin
                            state_d = ST_FAULT;
                            code_d  = FC_SHORT;
                        end else begin
                            phase_d = lamp_ph;
                            t_load  = 1'b1;
                            cd_d    = (phase_q == PH_YELLOW);
                        end
                    end else begin
                        state_d = ST_FAULT;
                        code_d  = FC_BAD_ORDER;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_ACQUIRE;
                end
            endcase
        end
    end

    assign fault_code = code_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: driver queues hand-computed
// expectations per sample, monitor pops and compares after each edge.
module tb_traffic_light_monitor;

    localparam int unsigned OKW = 4;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic           clk = 1'b0;
    logic           reset;
    logic           red, yellow, green;
    logic           clear_fault;
    logic           fault;
    logic [2:0]     fault_code;
    logic           tracking;
    logic [1:0]     phase;
    logic           cycle_done;
    logic [OKW-1:0] ok_cycles;

    traffic_light_monitor #(.OKCNT_W(OKW)) dut (
        .clk         (clk),
        .reset       (reset),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .clear_fault (clear_fault),
        .fault       (fault),
        .fault_code  (fault_code),
        .tracking    (tracking),
        .phase       (phase),
        .cycle_done  (cycle_done),
        .ok_cycles   (ok_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             chk;
        logic           f;
        logic [2:0]     code;
        logic           t;
        logic [1:0]     ph;
        logic           cd;
        logic [OKW-1:0] ok;
        string          name;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Monitor: one queue entry per sampled edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
                total++;
                if (fault !== e.f || fault_code !== e.code || tracking !== e.t ||
                    phase !== e.ph || cycle_done !== e.cd || ok_cycles !== e.ok) begin
                    bad++;
                    $display("FAIL %s: got f=%0d code=%0d trk=%0d ph=%0d cd=%0d ok=%0d want f=%0d code=%0d trk=%0d ph=%0d cd=%0d ok=%0d",
                             e.name, fault, fault_code, tracking, phase, cycle_done, ok_cycles,
                             e.f, e.code, e.t, e.ph, e.cd, e.ok);
                end
            end
        end
    end

    task automatic step(input logic [2:0] l, input logic clr, input logic rst, input exp_t e);
        @(negedge clk);
        {red, yellow, green} = l;
        clear_fault = clr;
        reset = rst;
        q.push_back(e);
    endtask

    task automatic go(input logic [2:0] l, input int n);
        exp_t e;
        e.chk = 1'b0;
        e.name = "";
        repeat (n) step(l, 1'b0, 1'b0, e);
    endtask

    task automatic ck(input logic [2:0] l, input logic clr, input logic rst,
                      input logic f, input logic [2:0] code, input logic t,
                      input logic [1:0] ph, input logic cd, input int ok, input string name);
        exp_t e;
        e.chk = 1'b1;
        e.f = f; e.code = code; e.t = t; e.ph = ph; e.cd = cd;
        e.ok = OKW'(ok);
        e.name = name;
        step(l, clr, rst, e);
    endtask

    initial begin
        exp_t nc;
        int p;
        logic [2:0] l;
        nc.chk = 1'b0;
        nc.name = "";
        reset = 1'b1;
        clear_fault = 1'b0;
        {red, yellow, green} = 3'b000;

        step(R, 1'b0, 1'b1, nc);
        ck(R, 0, 1, 0, 0, 0, 3, 0, 0, "reset");

        // Clean controller sequence: RED 5, GREEN 5, YELLOW 2
        for (int k = 1; k <= 40; k++) begin
            p = (k - 1) % 12;
            l = (p < 5) ? R : ((p < 10) ? G : Y);
            case (k)
                5:  ck(l, 0, 0, 0, 0, 0, 0, 0, 0, "acq_red");
                6:  ck(l, 0, 0, 0, 0, 1, 1, 0, 0, "enter_track");
                12: ck(l, 0, 0, 0, 0, 1, 2, 0, 0, "yellow");
                13: ck(l, 0, 0, 0, 0, 1, 0, 1, 1, "cycle1");
                14: ck(l, 0, 0, 0, 0, 1, 0, 0, 1, "cd_pulse_end");
                25: ck(l, 0, 0, 0, 0, 1, 0, 1, 2, "cycle2");
                37: ck(l, 0, 0, 0, 0, 1, 0, 1, 3, "cycle3");
                40: ck(l, 0, 0, 0, 0, 1, 0, 0, 3, "run40");
                default: step(l, 1'b0, 1'b0, nc);
            endcase
        end

        // Not one-hot mid GREEN, then a SHORT that must not overwrite the code
        go(R, 1);
        go(G, 2);
        ck(3'b101, 0, 0, 1, 1, 0, 1, 0, 3, "not_onehot");
        ck(Y,      0, 0, 1, 1, 0, 1, 0, 3, "sticky_code");

        // Clear coincident with another violation
        ck(3'b111, 1, 0, 0, 0, 0, 3, 0, 3, "clear_vs_fault");

        // SHORT: RED 5, GREEN 4, YELLOW
        ck(Y, 0, 0, 0, 0, 0, 2, 0, 3, "acq_first");
        ck(R, 0, 0, 0, 0, 1, 0, 0, 3, "acq_yr_no_cd");
        go(R, 4);
        go(G, 4);
        ck(Y, 0, 0, 1, 3, 0, 1, 0, 3, "short");
        ck(3'b000, 1, 0, 0, 0, 0, 3, 0, 3, "clear_illegal");

        // LONG: YELLOW held 3 in TRACK
        go(G, 1);
        ck(Y, 0, 0, 0, 0, 1, 2, 0, 3, "y1");
        ck(Y, 0, 0, 0, 0, 1, 2, 0, 3, "y2");
        ck(Y, 0, 0, 1, 4, 0, 2, 0, 3, "long");
        ck(Y, 1, 0, 0, 0, 0, 3, 0, 3, "clear2");

        // BAD_ORDER: GREEN straight to RED (in TRACK, then in ACQUIRE)
        go(R, 1);
        go(G, 5);
        ck(R, 0, 0, 1, 2, 0, 1, 0, 3, "bad_order");
        ck(G, 1, 0, 0, 0, 0, 3, 0, 3, "clear3");
        go(G, 1);
        ck(R, 0, 0, 1, 2, 0, 1, 0, 3, "acq_bad_order");
        ck(3'b000, 1, 0, 0, 0, 0, 3, 0, 3, "clear4");

        // Reset mid GREEN, then resync through ACQUIRE without a fault
        go(R, 1);
        go(G, 2);
        ck(G, 0, 1, 0, 0, 0, 3, 0, 0, "reset_mid");
        go(G, 2);
        ck(Y, 0, 0, 0, 0, 1, 2, 0, 0, "resync");

        // Saturation of a 4-bit counter over 17 full cycles
        ck(R, 0, 1, 0, 0, 0, 3, 0, 0, "reset2");
        go(R, 5);
        for (int i = 1; i <= 17; i++) begin
            go(G, 5);
            go(Y, 2);
            ck(R, 0, 0, 0, 0, 1, 0, 1, (i > 15) ? 15 : i, "sat");
            go(R, 4);
        end

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        if (q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: got %0d pending entries want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
